// File: rtl/ram_dma_ci_param.sv
// Custom-instruction DMA engine with a dual-port scratch memory and a burst bus master.
// Optional irq output is enabled by defining RAM_DMA_CI_IRQ_EN.
module ram_dma_ci_param #(
  parameter logic [7:0] customId      = 8'h00,
  parameter int         MEM_ADDR_BITS = 9
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  ciN,
  input  logic [31:0] valueA,
  input  logic [31:0] valueB,
  output logic        done,
  output logic [31:0] result,
  output logic        requestTransaction,
  input  logic        transactionGranted,
  input  logic [31:0] addressDataIn,
  input  logic        dataValidIn,
  input  logic        endTransactionIn,
  input  logic        busErrorIn,
  input  logic        busyIn,
  output logic        beginTransactionOut,
  output logic [31:0] addressDataOut,
  output logic [7:0]  burstSizeOut,
  output logic        readNotWriteOut,
  output logic [3:0]  byteEnablesOut,
  output logic        dataValidOut,
  output logic        endTransactionOut,
`ifdef RAM_DMA_CI_IRQ_EN
  output logic        irq,
`endif
  output logic [2:0]  dma_state
);
  localparam int A  = MEM_ADDR_BITS;
  localparam int LW = (A + 1 > 9) ? A + 1 : 9;
  localparam logic [A-1:0] PTR_ONE = A'(1);
  localparam logic [A:0]   REM_ONE = (A+1)'(1);

  typedef enum logic [2:0] {
    IDLE, REQUEST, INIT, RD_BURST, WR_PREFETCH, WR_BURST, WR_END, ERROR
  } state_t;

  state_t state, state_nx;

  logic         ci_hit, ci_we;
  logic [2:0]   ci_sel;
  logic [A-1:0] ci_addr;

  logic [31:0]  cfg_bus_addr;
  logic [A-1:0] cfg_mem_addr;
  logic [A:0]   cfg_block;
  logic [7:0]   cfg_burst;

  logic [31:0]  sh_bus_addr;
  logic [A-1:0] sh_mem_ptr;
  logic [A:0]   sh_remaining;
  logic [7:0]   sh_burst;
  logic         sh_dir_read;
  logic [8:0]   burst_left;

  logic         st_err, st_done;
  logic         start_ok, rd_take, wr_take, xfer_done;
  logic [A:0]   rem_after;
  logic [LW-1:0] burst_words, rem_words, burst_len;

  logic         rd_valid, rd_mem;
  logic [31:0]  rd_reg_q, reg_rd;
  logic [31:0]  mem_a_q, mem_b_q;
  logic [A-1:0] b_addr;
  logic [31:0]  mem [2**A];

  assign ci_hit  = start && (ciN == customId) && reset;
  assign ci_we   = valueA[A];
  assign ci_sel  = valueA[A+3:A+1];
  assign ci_addr = valueA[A-1:0];

  // Only an idle engine accepts a start; bit0 (bus->memory) wins over bit1.
  assign start_ok = ci_hit && ci_we && (ci_sel == 3'd5) && (state == IDLE)
                    && (valueB[0] || valueB[1]);

  assign rd_take   = reset && (state == RD_BURST) && dataValidIn && !busErrorIn
                     && (sh_remaining != '0);
  assign wr_take   = reset && (state == WR_BURST) && !busyIn && !busErrorIn;
  assign rem_after = rd_take ? sh_remaining - REM_ONE : sh_remaining;
  assign xfer_done = ((state == RD_BURST) && !busErrorIn && endTransactionIn
                      && (rem_after == '0))
                     || ((state == WR_END) && (sh_remaining == '0));

  assign burst_words = LW'(sh_burst) + LW'(1);
  assign rem_words   = LW'(sh_remaining);
  assign burst_len   = (burst_words < rem_words) ? burst_words : rem_words;

  // Port B read address runs one word ahead whenever the current word is consumed.
  assign b_addr = wr_take ? sh_mem_ptr + PTR_ONE : sh_mem_ptr;

  assign done      = (ci_hit && ci_we) || rd_valid;
  assign result    = rd_valid ? (rd_mem ? mem_a_q : rd_reg_q) : '0;
  assign dma_state = state;

  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:        if (start_ok && (cfg_block != '0)) state_nx = REQUEST;
      REQUEST:     if (transactionGranted) state_nx = INIT;
      INIT:        if (busErrorIn)        state_nx = ERROR;
                   else if (sh_dir_read)  state_nx = RD_BURST;
                   else                   state_nx = WR_PREFETCH;
      RD_BURST:    if (busErrorIn)            state_nx = ERROR;
                   else if (endTransactionIn) state_nx = (rem_after != '0) ? REQUEST : IDLE;
      WR_PREFETCH: state_nx = busErrorIn ? ERROR : WR_BURST;
      WR_BURST:    if (busErrorIn)                          state_nx = ERROR;
                   else if (!busyIn && (burst_left == 9'd1)) state_nx = WR_END;
      WR_END:      state_nx = (sh_remaining != '0) ? REQUEST : IDLE;
      ERROR:       state_nx = IDLE;
      default:     state_nx = IDLE;
    endcase
  end

  always_comb begin
    requestTransaction  = 1'b0;
    beginTransactionOut = 1'b0;
    addressDataOut      = '0;
    burstSizeOut        = '0;
    readNotWriteOut     = 1'b0;
    byteEnablesOut      = '0;
    dataValidOut        = 1'b0;
    endTransactionOut   = 1'b0;
    case (state)
      REQUEST: requestTransaction = 1'b1;
      INIT: begin
        beginTransactionOut = 1'b1;
        addressDataOut      = sh_bus_addr;
        burstSizeOut        = burst_len[7:0] - 8'd1;
        readNotWriteOut     = sh_dir_read;
        byteEnablesOut      = 4'hF;
      end
      WR_BURST: begin
        dataValidOut   = 1'b1;
        addressDataOut = mem_b_q;
      end
      WR_END:  endTransactionOut = 1'b1;
      ERROR:   endTransactionOut = !sh_dir_read;
      default: ;
    endcase
  end

  always_comb begin
    reg_rd = '0;
    case (ci_sel)
      3'd1:    reg_rd = cfg_bus_addr;
      3'd2:    reg_rd = 32'(cfg_mem_addr);
      3'd3:    reg_rd = 32'(cfg_block);
      3'd4:    reg_rd = {24'd0, cfg_burst};
      3'd5:    reg_rd = {29'd0, st_done, st_err, state != IDLE};
      default: reg_rd = '0;
    endcase
  end

  // Configuration registers stay writable while busy; transfers run on shadows.
  always_ff @(posedge clock) begin
    if (!reset) begin
      cfg_bus_addr <= '0;
      cfg_mem_addr <= '0;
      cfg_block    <= '0;
      cfg_burst    <= '0;
      sh_bus_addr  <= '0;
      sh_mem_ptr   <= '0;
      sh_remaining <= '0;
      sh_burst     <= '0;
      sh_dir_read  <= 1'b0;
      burst_left   <= '0;
      st_err       <= 1'b0;
      st_done      <= 1'b0;
      rd_valid     <= 1'b0;
      rd_mem       <= 1'b0;
      rd_reg_q     <= '0;
    end else begin
      if (ci_hit && ci_we) begin
        case (ci_sel)
          3'd1:    cfg_bus_addr <= {valueB[31:2], 2'b00};
          3'd2:    cfg_mem_addr <= valueB[A-1:0];
          3'd3:    cfg_block    <= valueB[A:0];
          3'd4:    cfg_burst    <= valueB[7:0];
          default: ;
        endcase
      end
      if (start_ok) begin
        st_err       <= 1'b0;
        st_done      <= (cfg_block == '0);
        sh_bus_addr  <= cfg_bus_addr;
        sh_mem_ptr   <= cfg_mem_addr;
        sh_remaining <= cfg_block;
        sh_burst     <= cfg_burst;
        sh_dir_read  <= valueB[0];
      end
      if (state == INIT) burst_left <= burst_len[8:0];
      if (rd_take || wr_take) begin
        sh_bus_addr  <= sh_bus_addr + 32'd4;
        sh_mem_ptr   <= sh_mem_ptr + PTR_ONE;
        sh_remaining <= sh_remaining - REM_ONE;
      end
      if (wr_take)          burst_left <= burst_left - 9'd1;
      if (xfer_done)        st_done    <= 1'b1;
      if (state == ERROR)   st_err     <= 1'b1;
      rd_valid <= ci_hit && !ci_we;
      rd_mem   <= (ci_sel == 3'd0);
      rd_reg_q <= reg_rd;
    end
  end

  // Port B write is last so a same-address DMA write overrides the CI write.
  always_ff @(posedge clock) begin
    if (ci_hit && ci_we && (ci_sel == 3'd0)) mem[ci_addr] <= valueB;
    if (rd_take) mem[sh_mem_ptr] <= addressDataIn;
    mem_a_q <= mem[ci_addr];
    if ((state != WR_BURST) || wr_take) mem_b_q <= mem[b_addr];
  end

`ifdef RAM_DMA_CI_IRQ_EN
  logic cfg_irq_en;
  always_ff @(posedge clock) begin
    if (!reset) begin
      cfg_irq_en <= 1'b0;
      irq        <= 1'b0;
    end else begin
      if (ci_hit && ci_we && (ci_sel == 3'd5)) cfg_irq_en <= valueB[2];
      irq <= cfg_irq_en && (xfer_done
                            || (start_ok && (cfg_block == '0))
                            || ((state_nx == ERROR) && (state != ERROR)));
    end
  end
`endif

  logic unused_bits;
  assign unused_bits = ^{valueA[31:A+4], burst_len[LW-1:9]};

endmodule
